// File: rtl/fme_half_sad_sel.sv
// fme_half_sad_sel: accumulates 9 half-pel candidate SADs over a block and picks the best offset
module fme_half_sad_sel #(
  parameter int BLK_PIX = 16,
  parameter int SAD_W   = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       cur_pix,
  input  logic [71:0]      cand_flat,
  output logic             busy,
  output logic             done,
  output logic [3:0]       best_idx,
  output logic [SAD_W-1:0] best_sad
);
  localparam int CNT_W = $clog2(BLK_PIX) + 1;
  typedef enum logic [1:0] {IDLE, ACCUM, CMP, DONE} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [3:0] pos, cmp_idx, run_idx, nx_idx;
  logic [SAD_W-1:0] sad [9];
  logic [SAD_W-1:0] run_sad, nx_sad, cmp_sad;
  logic [8:0] ad [9];
  logic last_beat, last_cmp, take;
  genvar i;
  generate
    for (i = 0; i < 9; i++) begin : g_ad
      assign ad[i] = (cand_flat[8*i+:8] >= cur_pix) ? {1'b0, cand_flat[8*i+:8]} - {1'b0, cur_pix}
                                                     : {1'b0, cur_pix} - {1'b0, cand_flat[8*i+:8]};
    end
  endgenerate
  // compare walk: position 0 visits the centre, then 0..3 and 5..8; strict < keeps earlier winners on ties
  always_comb begin
    last_beat = (state == ACCUM) && in_valid && (cnt == CNT_W'(BLK_PIX - 1));
    last_cmp  = (state == CMP) && (pos == 4'd8);
    cmp_idx   = (pos == 4'd0) ? 4'd4 : (pos <= 4'd4) ? pos - 4'd1 : pos;
    cmp_sad   = sad[cmp_idx];
    take      = (pos == 4'd0) || (cmp_sad < run_sad);
    nx_idx    = take ? cmp_idx : run_idx;
    nx_sad    = take ? cmp_sad : run_sad;
  end
  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end
  // next state and status outputs
  always_comb begin
    state_nx = state;
    if (state == IDLE && start) state_nx = ACCUM;
    if (last_beat)              state_nx = CMP;
    if (last_cmp)               state_nx = DONE;
    if (state == DONE)          state_nx = IDLE;
    in_ready = (state == ACCUM);
    busy     = (state != IDLE);
    done     = (state == DONE);
  end
  // accumulators, compare walk and registered result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      pos      <= '0;
      run_idx  <= 4'd4;
      run_sad  <= '0;
      best_idx <= 4'd4;
      best_sad <= '0;
      for (int k = 0; k < 9; k++) sad[k] <= '0;
    end else begin
      if (state == IDLE && start) begin
        cnt <= '0;
        for (int k = 0; k < 9; k++) sad[k] <= '0;
      end
      if (state == ACCUM && in_valid) begin
        cnt <= cnt + 1'b1;
        for (int k = 0; k < 9; k++) sad[k] <= sad[k] + SAD_W'(ad[k]);
      end
      if (state == CMP) begin
        run_idx <= nx_idx;
        run_sad <= nx_sad;
        pos     <= last_cmp ? 4'd0 : pos + 4'd1;
      end
      if (last_cmp) begin
        best_idx <= nx_idx;
        best_sad <= nx_sad;
      end
    end
  end
endmodule
